router_fifo_arb: RTL

Round-robin, packet-aware arbiter that shares one output FIFO between NUM_IN input FIFOs inside the router. It watches the inputs' empty flags and the output's full flag. It drives the pops and the push, moving at most one flit per cycle. It holds its grant on one input from head flit to tail flit, so packets never interleave at the output.

---
 rtl/router_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/router_fifo_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/router_arb_pkg.sv
// Shared types and flit-format constants for the router output arbiter.
package router_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } t_arb_state;

    // Offsets from the flit width: TAIL is bit DATA_WIDTH-1, HEAD is bit DATA_WIDTH-2.
    localparam int TAIL_BIT = 1;
    localparam int HEAD_BIT = 2;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: returns the first set request at or above ptr, wrapping.
module rr_pick #(
    parameter  int NUM_IN = 4,
    localparam int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin : pick
        int j;
        // NOTE: every signal written here gets a default first so no latch is inferred.
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        // Scan from the farthest candidate down so the nearest one to ptr wins.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_IN) begin
                j = j - NUM_IN;
            end
            if (req[j]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/router_fifo_arb.sv
// Packet-aware round-robin arbiter moving at most one flit per cycle from NUM_IN
// input FIFOs into one output FIFO, holding the grant from head flit to tail flit.
module router_fifo_arb
    import router_arb_pkg::*;
#(
    parameter  int NUM_IN     = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int IDX_W      = $clog2(NUM_IN)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_IN-1:0]                    in_empty,
    input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    in_pop_data,
    output logic [NUM_IN-1:0]                    in_pop,
    input  logic                                 out_full,
    output logic                                 out_push,
    output logic [DATA_WIDTH-1:0]                out_push_data,
    output logic [IDX_W-1:0]                     grant_id,
    output logic                                 busy,
    output logic [15:0]                          pkt_cnt,
    output logic                                 proto_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    t_arb_state       state_q,     state_d;
    logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0] lock_id_q,   lock_id_d;
    logic [IDX_W-1:0] grant_id_q,  grant_id_d;
    logic [15:0]      pkt_cnt_q,   pkt_cnt_d;
    logic             proto_err_q, proto_err_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel;
    logic             xfer;
    logic             is_head;
    logic             is_tail;

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
        return (v == LAST_IDX) ? '0 : v + IDX_W'(1);
    endfunction

    rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_pick (
        .req   (~in_empty),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign sel     = (state_q == LOCKED) ? lock_id_q : pick_idx;
    assign is_tail = out_push_data[DATA_WIDTH-TAIL_BIT];
    assign is_head = out_push_data[DATA_WIDTH-HEAD_BIT];

    // A locked packet waits on its own input even when other inputs have data.
    assign xfer = rst && !out_full &&
                  ((state_q == LOCKED) ? !in_empty[lock_id_q] : pick_valid);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_id_d     = lock_id_q;
        grant_id_d    = grant_id_q;
        pkt_cnt_d     = pkt_cnt_q;
        proto_err_d   = proto_err_q;
        in_pop        = '0;
        out_push      = 1'b0;
        out_push_data = in_pop_data[sel];

        if (xfer) begin
            in_pop[sel] = 1'b1;
            out_push    = 1'b1;
            grant_id_d  = sel;

            // A packet must open with HEAD and carry no HEAD once locked.
            if ((state_q == IDLE && !is_head) || (state_q == LOCKED && is_head)) begin
                proto_err_d = 1'b1;
            end

            if (is_tail) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
                state_d   = IDLE;
                rr_ptr_d  = inc_wrap(sel);
            end else if (state_q == IDLE) begin
                state_d   = LOCKED;
                lock_id_d = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_id_q   <= '0;
            grant_id_q  <= '0;
            pkt_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register updates together at the edge.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_id_q   <= lock_id_d;
            grant_id_q  <= grant_id_d;
            pkt_cnt_q   <= pkt_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign grant_id  = grant_id_q;
    assign busy      = (state_q == LOCKED);
    assign pkt_cnt   = pkt_cnt_q;
    assign proto_err = proto_err_q;

`ifndef SYNTHESIS
    a_pop_nonempty : assert property (@(posedge clk) disable iff (!rst)
        (in_pop & in_empty) == '0);
    a_push_not_full : assert property (@(posedge clk) disable iff (!rst)
        !(out_push && out_full));
    a_pop_onehot0 : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(in_pop));
`endif

endmodule
